// File: rtl/frame_pixel_reader.sv
// Word FIFO: single-clock circular buffer, DEPTH a power of two.
// Latency: a word pushed in cycle N is the head in cycle N+1.
// Backpressure: none internally; the writer must never push when full.
module fpr_word_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// Frame reader: Avalon-MM read master fetching 32-bit words, emitting RGB565 pixels.
// Latency: start -> m_read next cycle; pushed word visible as pixel the following cycle.
// Backpressure: pix_ready stalls the FIFO; reads stop while FIFO plus in-flight word is full.
module frame_pixel_reader #(
    parameter int ADDR_W     = 27,
    parameter int LEN_W      = 20,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    input  logic              m_waitrequest,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid,
    output logic              m_lock,
    output logic [15:0]       pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_last
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DRAIN} state_t;

    state_t           state;
    logic [LEN_W-1:0] words_left;
    logic [LEN_W:0]   pix_left;
    logic             outstanding;
    logic             half;
    logic             first_pix;

    logic [31:0]      fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             accept;
    logic             push;
    logic             pop;
    logic             pix_fire;
    logic [CNT_W:0]   occupancy;
    logic             can_issue;

    assign accept    = m_read & ~m_waitrequest;
    // Read data is only trusted in the acceptance cycle or while waiting for it,
    // which also drops any stale response left over from before a reset.
    assign push      = (state == ISSUE && accept && m_readdatavalid) ||
                       (state == WAIT_DATA && m_readdatavalid);
    assign pix_valid = (fifo_count != '0);
    assign pix_fire  = pix_valid & pix_ready;
    assign pop       = pix_fire & half;
    assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(outstanding);
    assign can_issue = (occupancy < (CNT_W+1)'(FIFO_DEPTH)) && (words_left != '0);

    assign pix_data  = !pix_valid ? 16'h0000 : (half ? fifo_head[31:16] : fifo_head[15:0]);
    assign pix_sof   = pix_valid & first_pix;
    assign pix_last  = pix_valid & (pix_left == (LEN_W+1)'(1));
    assign m_lock    = 1'b0;

    fpr_word_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (m_readdata),
        .pop      (pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            words_left  <= '0;
            pix_left    <= '0;
            outstanding <= 1'b0;
            half        <= 1'b0;
            first_pix   <= 1'b0;
            m_address   <= '0;
            m_read      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;

            if (pix_fire) begin
                half      <= ~half;
                pix_left  <= pix_left - (LEN_W+1)'(1);
                first_pix <= 1'b0;
            end

            case (state)
                IDLE: begin
                    m_read <= 1'b0;
                    busy   <= 1'b0;
                    if (start) begin
                        m_address   <= base_addr & ~ADDR_W'(3);
                        words_left  <= num_words;
                        pix_left    <= {num_words, 1'b0};
                        outstanding <= 1'b0;
                        half        <= 1'b0;
                        first_pix   <= 1'b1;
                        busy        <= 1'b1;
                        // The FIFO is always empty here, so the first read can go out at once.
                        if (num_words == '0) begin
                            done <= 1'b1;
                        end else begin
                            m_read <= 1'b1;
                            state  <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (accept) begin
                        m_read     <= 1'b0;
                        m_address  <= m_address + ADDR_W'(4);
                        words_left <= words_left - LEN_W'(1);
                        if (!m_readdatavalid) begin
                            outstanding <= 1'b1;
                            state       <= WAIT_DATA;
                        end
                    end else if (!m_read) begin
                        if (can_issue) begin
                            m_read <= 1'b1;
                        end else if (words_left == '0 && !outstanding) begin
                            state <= DRAIN;
                        end
                    end
                end

                WAIT_DATA: begin
                    if (m_readdatavalid) begin
                        outstanding <= 1'b0;
                        state       <= ISSUE;
                    end
                end

                DRAIN: begin
                    if (pix_left == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_pixel_reader.sv
// Bench for frame_pixel_reader: behavioural Avalon slave with memory, pixel sink, per-scenario checks.
module tb_frame_pixel_reader;
    logic        clock;
    logic        reset_n;
    logic        start;
    logic [26:0] base_addr;
    logic [19:0] num_words;
    logic        busy;
    logic        done;
    logic [26:0] m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;
    logic        m_lock;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic        pix_last;

    int checks   = 0;
    int failures = 0;

    // Scenario configuration (written by tasks only).
    int wait_cycles = 0;
    int lat         = 0;
    int ready_mode  = 1;
    int stale_req   = 0;

    // Observation logs (written by the slave/sink processes only).
    logic [26:0] acc_addr [$];
    logic [15:0] cap_pix  [$];
    logic        cap_sof  [$];
    logic        cap_last [$];
    int done_cnt = 0, read_cyc = 0, stall_total = 0, addr_chg = 0, overlap_err = 0;
    int stale_done = 0;

    // Reference: word memory and expected streams for the current transfer.
    logic [31:0] mem [int unsigned];
    logic [15:0] exp_pix  [$];
    logic [26:0] exp_addr [$];
    int pix_base, acc_base, done_base, read_base;

    frame_pixel_reader dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .base_addr       (base_addr),
        .num_words       (num_words),
        .busy            (busy),
        .done            (done),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .m_lock          (m_lock),
        .pix_data        (pix_data),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .pix_sof         (pix_sof),
        .pix_last        (pix_last)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rd_word(input logic [26:0] a);
        int unsigned k;
        k = int'(a[26:2]);
        return mem.exists(k) ? mem[k] : 32'hDEAD_BEEF;
    endfunction

    // Avalon slave: configurable stall before acceptance and read latency.
    int pend = 0;
    int stall = 0;
    logic [26:0] pend_addr, stall_addr;
    always @(negedge clock) begin
        m_readdatavalid = 1'b0;
        m_readdata      = $urandom;
        if (!reset_n) begin
            pend = 0;
            stall = 0;
            m_waitrequest = 1'b0;
        end else begin
            if (m_read && pend > 0) overlap_err++;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    m_readdatavalid = 1'b1;
                    m_readdata      = rd_word(pend_addr);
                end
            end
            if (stale_req != stale_done) begin
                m_readdatavalid = 1'b1;
                m_readdata      = 32'h5A5A_A5A5;
                stale_done++;
            end
            if (m_read) begin
                if (stall > 0 && m_address != stall_addr) addr_chg++;
                if (stall < wait_cycles) begin
                    if (stall == 0) stall_addr = m_address;
                    m_waitrequest = 1'b1;
                    stall++;
                    stall_total++;
                end else begin
                    m_waitrequest = 1'b0;
                    stall = 0;
                    acc_addr.push_back(m_address);
                    if (lat == 0) begin
                        m_readdatavalid = 1'b1;
                        m_readdata      = rd_word(m_address);
                    end else begin
                        pend      = lat;
                        pend_addr = m_address;
                    end
                end
            end else begin
                m_waitrequest = 1'b0;
            end
        end
    end

    // Pixel sink and event monitor.
    always @(negedge clock) begin
        case (ready_mode)
            0:       pix_ready = 1'b0;
            1:       pix_ready = 1'b1;
            default: pix_ready = 1'($urandom_range(0, 1));
        endcase
        if (reset_n && pix_valid && pix_ready) begin
            cap_pix.push_back(pix_data);
            cap_sof.push_back(pix_sof);
            cap_last.push_back(pix_last);
        end
        if (reset_n && done)   done_cnt++;
        if (reset_n && m_read) read_cyc++;
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic start_xfer(input logic [26:0] b, input int n, input logic [31:0] w0, input bit fix0);
        logic [26:0] a;
        logic [31:0] w;
        mem.delete();
        exp_pix.delete();
        exp_addr.delete();
        for (int i = 0; i < n; i++) begin
            a = {b[26:2], 2'b00} + 27'(4 * i);
            w = (fix0 && i == 0) ? w0 : $urandom;
            mem[int'(a[26:2])] = w;
            exp_addr.push_back(a);
            exp_pix.push_back(w[15:0]);
            exp_pix.push_back(w[31:16]);
        end
        pix_base  = cap_pix.size();
        acc_base  = acc_addr.size();
        done_base = done_cnt;
        read_base = read_cyc;
        base_addr = b;
        num_words = 20'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            if (done_cnt > done_base) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++; if ({m_read, busy, done, pix_valid, m_lock, pix_sof, pix_last} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000000", {m_read, busy, done, pix_valid, m_lock, pix_sof, pix_last});
        end
        checks++; if (m_address !== 27'd0 || pix_data !== 16'd0) begin
            failures++; $display("FAIL reset_data addr=%h pix=%h exp=0", m_address, pix_data);
        end
        reset_n = 1'b1;
        repeat (2) tick();
        checks++; if (busy !== 1'b0 || m_read !== 1'b0) begin
            failures++; $display("FAIL reset_idle busy=%b m_read=%b exp=0", busy, m_read);
        end
    endtask

    task automatic test_single();
        bit ok;
        wait_cycles = 0; lat = 0; ready_mode = 1;
        start_xfer(27'h100, 1, 32'hBBBB_AAAA, 1'b1);
        checks++; if (m_read !== 1'b1 || m_address !== 27'h100) begin
            failures++; $display("FAIL single_issue m_read=%b addr=%h exp=1/100", m_read, m_address);
        end
        checks++; if (busy !== 1'b1) begin
            failures++; $display("FAIL single_busy got=%b exp=1", busy);
        end
        wait_done(200, ok);
        repeat (4) tick();
        checks++; if (!ok || done_cnt - done_base != 1) begin
            failures++; $display("FAIL single_done ok=%0d pulses=%0d exp=1", ok, done_cnt - done_base);
        end
        checks++; if (cap_pix.size() - pix_base != 2) begin
            failures++; $display("FAIL single_count got=%0d exp=2", cap_pix.size() - pix_base);
        end else begin
            checks++; if (cap_pix[pix_base] !== 16'hAAAA || cap_sof[pix_base] !== 1'b1 || cap_last[pix_base] !== 1'b0) begin
                failures++; $display("FAIL single_pix0 got=%h sof=%b last=%b exp=aaaa/1/0", cap_pix[pix_base], cap_sof[pix_base], cap_last[pix_base]);
            end
            checks++; if (cap_pix[pix_base+1] !== 16'hBBBB || cap_sof[pix_base+1] !== 1'b0 || cap_last[pix_base+1] !== 1'b1) begin
                failures++; $display("FAIL single_pix1 got=%h sof=%b last=%b exp=bbbb/0/1", cap_pix[pix_base+1], cap_sof[pix_base+1], cap_last[pix_base+1]);
            end
        end
        checks++; if (busy !== 1'b0 || acc_addr.size() - acc_base != 1) begin
            failures++; $display("FAIL single_end busy=%b reads=%0d exp=0/1", busy, acc_addr.size() - acc_base);
        end
    endtask

    task automatic test_zero_unaligned();
        bit ok;
        wait_cycles = 0; lat = 0; ready_mode = 1;
        start_xfer(27'h40, 0, 32'h0, 1'b0);
        checks++; if (done !== 1'b1 || m_read !== 1'b0) begin
            failures++; $display("FAIL zero_done done=%b m_read=%b exp=1/0", done, m_read);
        end
        repeat (5) tick();
        checks++; if (done_cnt - done_base != 1 || read_cyc != read_base) begin
            failures++; $display("FAIL zero_quiet pulses=%0d read_cycles=%0d exp=1/0", done_cnt - done_base, read_cyc - read_base);
        end
        start_xfer(27'h103, 2, 32'h0, 1'b0);
        checks++; if (m_read !== 1'b1 || m_address !== 27'h100) begin
            failures++; $display("FAIL unaligned_addr m_read=%b addr=%h exp=1/100", m_read, m_address);
        end
        wait_done(300, ok);
        repeat (3) tick();
        checks++; if (!ok || cap_pix.size() - pix_base != 4 || cap_pix[pix_base+3] !== exp_pix[3]) begin
            failures++; $display("FAIL unaligned_stream ok=%0d n=%0d exp=4", ok, cap_pix.size() - pix_base);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        wait_cycles = 0; lat = 0; ready_mode = 0;
        start_xfer(27'h0, 16, 32'h0, 1'b0);
        repeat (80) tick();
        checks++; if (acc_addr.size() - acc_base != 8 || m_read !== 1'b0) begin
            failures++; $display("FAIL bp_stall reads=%0d m_read=%b exp=8/0", acc_addr.size() - acc_base, m_read);
        end
        for (int i = 0; i < 8 && acc_base + i < acc_addr.size(); i++) begin
            checks++; if (acc_addr[acc_base+i] !== 27'(4 * i)) begin
                failures++; $display("FAIL bp_addr[%0d] got=%h exp=%h", i, acc_addr[acc_base+i], 27'(4 * i));
            end
        end
        ready_mode = 1;
        wait_done(1000, ok);
        repeat (3) tick();
        n = cap_pix.size() - pix_base;
        checks++; if (!ok || n != 32 || acc_addr.size() - acc_base != 16) begin
            failures++; $display("FAIL bp_total ok=%0d pixels=%0d reads=%0d exp=32/16", ok, n, acc_addr.size() - acc_base);
        end
        for (int i = 0; i < n && i < exp_pix.size(); i++) begin
            checks++; if (cap_pix[pix_base+i] !== exp_pix[i] || cap_sof[pix_base+i] !== (i == 0) || cap_last[pix_base+i] !== (i == exp_pix.size() - 1)) begin
                failures++; $display("FAIL bp_pix[%0d] got=%h sof=%b last=%b exp=%h", i, cap_pix[pix_base+i], cap_sof[pix_base+i], cap_last[pix_base+i], exp_pix[i]);
            end
        end
    endtask

    task automatic test_delayed();
        bit ok;
        int n, s0, c0, o0;
        wait_cycles = 3; lat = 2; ready_mode = 1;
        s0 = stall_total; c0 = addr_chg; o0 = overlap_err;
        start_xfer(27'($urandom) & 27'h0FF_FFFC, 4, 32'h0, 1'b0);
        wait_done(500, ok);
        repeat (3) tick();
        checks++; if (!ok || stall_total - s0 != 12) begin
            failures++; $display("FAIL delay_stalls ok=%0d stalls=%0d exp=12", ok, stall_total - s0);
        end
        checks++; if (addr_chg != c0 || overlap_err != o0) begin
            failures++; $display("FAIL delay_protocol addr_changes=%0d overlaps=%0d exp=0/0", addr_chg - c0, overlap_err - o0);
        end
        n = cap_pix.size() - pix_base;
        checks++; if (n != 8) begin
            failures++; $display("FAIL delay_count got=%0d exp=8", n);
        end
        for (int i = 0; i < n && i < exp_pix.size(); i++) begin
            checks++; if (cap_pix[pix_base+i] !== exp_pix[i]) begin
                failures++; $display("FAIL delay_pix[%0d] got=%h exp=%h", i, cap_pix[pix_base+i], exp_pix[i]);
            end
        end
    endtask

    task automatic test_busy_start();
        bit ok;
        int n;
        wait_cycles = 1; lat = 1; ready_mode = 2;
        start_xfer(27'h2000, 5, 32'h0, 1'b0);
        repeat (5) tick();
        checks++; if (busy !== 1'b1) begin
            failures++; $display("FAIL busy_mid got=%b exp=1", busy);
        end
        for (int k = 0; k < 2; k++) begin
            base_addr = 27'h5000; num_words = 20'd9; start = 1'b1;
            tick();
            start = 1'b0;
            repeat (3) tick();
        end
        wait_done(1000, ok);
        repeat (8) tick();
        n = cap_pix.size() - pix_base;
        checks++; if (!ok || done_cnt - done_base != 1 || busy !== 1'b0) begin
            failures++; $display("FAIL busy_done ok=%0d pulses=%0d busy=%b exp=1/0", ok, done_cnt - done_base, busy);
        end
        checks++; if (acc_addr.size() - acc_base != 5 || n != 10) begin
            failures++; $display("FAIL busy_len reads=%0d pixels=%0d exp=5/10", acc_addr.size() - acc_base, n);
        end
        for (int i = 0; i < n && i < exp_pix.size(); i++) begin
            checks++; if (cap_pix[pix_base+i] !== exp_pix[i]) begin
                failures++; $display("FAIL busy_pix[%0d] got=%h exp=%h", i, cap_pix[pix_base+i], exp_pix[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        wait_cycles = 5; lat = 0; ready_mode = 1;
        start_xfer(27'h200, 10, 32'h0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (m_read) ok = 1'b1;
            else tick();
        end
        checks++; if (!ok) begin
            failures++; $display("FAIL rstmid_read got=0 exp=1");
        end
        reset_n = 1'b0;
        #1;
        checks++; if ({m_read, busy, done, pix_valid} !== 4'b0) begin
            failures++; $display("FAIL rstmid_async got=%b exp=0000", {m_read, busy, done, pix_valid});
        end
        repeat (2) tick();
        wait_cycles = 0;
        reset_n = 1'b1;
        tick();
        stale_req++;
        repeat (3) tick();
        checks++; if ({m_read, busy, pix_valid} !== 3'b0) begin
            failures++; $display("FAIL rstmid_stale got=%b exp=000", {m_read, busy, pix_valid});
        end
        start_xfer(27'h300, 3, 32'h0, 1'b0);
        wait_done(300, ok);
        repeat (3) tick();
        n = cap_pix.size() - pix_base;
        checks++; if (!ok || n != 6 || acc_addr[acc_base] !== 27'h300) begin
            failures++; $display("FAIL rstmid_after ok=%0d pixels=%0d exp=6", ok, n);
        end
        for (int i = 0; i < n && i < exp_pix.size(); i++) begin
            checks++; if (cap_pix[pix_base+i] !== exp_pix[i]) begin
                failures++; $display("FAIL rstmid_pix[%0d] got=%h exp=%h", i, cap_pix[pix_base+i], exp_pix[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int n, nw;
        logic [26:0] b;
        for (int t = 0; t < 8; t++) begin
            wait_cycles = $urandom_range(0, 2);
            lat         = $urandom_range(0, 2);
            ready_mode  = 2;
            b  = (t == 0) ? 27'h7FF_FFF0 : 27'($urandom);
            nw = (t == 0) ? 8 : $urandom_range(1, 20);
            start_xfer(b, nw, 32'h0, 1'b0);
            wait_done(3000, ok);
            repeat (3) tick();
            n = cap_pix.size() - pix_base;
            checks++; if (!ok || n != 2 * nw || done_cnt - done_base != 1) begin
                failures++; $display("FAIL rand%0d_len ok=%0d pixels=%0d exp=%0d", t, ok, n, 2 * nw);
            end
            for (int i = 0; i < nw && acc_base + i < acc_addr.size(); i++) begin
                checks++; if (acc_addr[acc_base+i] !== exp_addr[i]) begin
                    failures++; $display("FAIL rand%0d_addr[%0d] got=%h exp=%h", t, i, acc_addr[acc_base+i], exp_addr[i]);
                end
            end
            for (int i = 0; i < n && i < exp_pix.size(); i++) begin
                checks++; if (cap_pix[pix_base+i] !== exp_pix[i] || cap_sof[pix_base+i] !== (i == 0) || cap_last[pix_base+i] !== (i == exp_pix.size() - 1)) begin
                    failures++; $display("FAIL rand%0d_pix[%0d] got=%h sof=%b last=%b exp=%h", t, i, cap_pix[pix_base+i], cap_sof[pix_base+i], cap_last[pix_base+i], exp_pix[i]);
                end
            end
        end
    endtask

    initial begin
        clock = 1'b0; reset_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        pix_ready = 1'b0; m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
        test_reset();
        test_single();
        test_zero_unaligned();
        test_backpressure();
        test_delayed();
        test_busy_start();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_pixel_reader.md
Name: frame_pixel_reader

Overview:
- Avalon-MM read master that fetches a frame buffer as 32-bit words and emits a 16-bit RGB565 pixel stream for the display path.
- Sits directly upstream of the 32-to-16 SDRAM read adapter: its master port drives that adapter's 32-bit slave (address, read, waitrequest, readdata, readdatavalid, lock).
- Software or the frame controller supplies base address and word count and pulses start. The block buffers words in a small FIFO and splits each word into two pixels.

Parameters:
- ADDR_W, 27, byte address width of the master port.
- LEN_W, 20, width of the word-count input.
- FIFO_DEPTH, 8, word-FIFO entries; power of two, minimum 2.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a transfer; honoured only in IDLE.
- base_addr  in  ADDR_W  byte address of the first word, sampled on an accepted start; bits [1:0] are ignored and forced to 0.
- num_words  in  LEN_W  number of 32-bit words to read, sampled on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the transfer completes.
- m_address  out  ADDR_W  read address.
- m_read  out  1  read request.
- m_waitrequest  in  1  slave stall.
- m_readdata  in  32  read data; [15:0] holds the lower-address halfword.
- m_readdatavalid  in  1  read data qualifier.
- m_lock  out  1  tied 0.
- pix_data  out  16  pixel, FIFO head halfword.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  downstream accept.
- pix_sof  out  1  qualifies the first pixel of a transfer.
- pix_last  out  1  qualifies the final pixel of a transfer.

Behaviour:
- Reset: every output is 0; the FSM goes to IDLE; the FIFO is empty; all counters are 0. Reset is asynchronous, so m_read drops immediately even mid-burst. Any in-flight read is abandoned, and stale readdatavalid after reset is ignored because the FSM is in IDLE.
- FSM states: IDLE, ISSUE, WAIT_DATA, DRAIN.
- IDLE, start=1:
  - Latch addr = base_addr with bits [1:0] cleared.
  - Set words_left = num_words and pix_left = 2*num_words (width LEN_W+1).
  - busy=1 next cycle.
  - If num_words=0, go to IDLE and pulse done one cycle after start, with no reads issued. Otherwise go to ISSUE.
- ISSUE:
  - Condition to assert the read: fifo_count + outstanding < FIFO_DEPTH and words_left != 0. When it holds, assert m_read=1 with m_address=addr.
  - Hold m_address and m_read stable while m_waitrequest=1.
  - Acceptance is the cycle in which m_read=1 and m_waitrequest=0. On acceptance, deassert m_read in the next cycle, set addr += 4, decrement words_left and set outstanding=1.
  - If m_readdatavalid=1 in the acceptance cycle (the normal case for the adapter), push the word that cycle and stay in ISSUE. Otherwise go to WAIT_DATA.
  - At most one read is outstanding. m_read is never asserted while outstanding=1.
- WAIT_DATA: on m_readdatavalid=1, push m_readdata into the FIFO, clear outstanding and return to ISSUE. While not in WAIT_DATA, m_readdatavalid is ignored except in the acceptance cycle.
- ISSUE leaves to DRAIN when words_left=0 and outstanding=0.
- DRAIN: wait until pix_left=0, then pulse done, drop busy and go to IDLE.
- Pixel output:
  - pix_valid=1 whenever the FIFO is non-empty.
  - A half-select bit chooses the pixel: pix_data = head[15:0] when half=0, head[31:16] when half=1.
  - On pix_valid & pix_ready, toggle half and decrement pix_left. When half was 1, pop the FIFO.
  - pix_sof = pix_valid and first pixel of the transfer. pix_last = pix_valid and pix_left=1.
- FIFO timing and boundaries:
  - Latency: a word pushed in cycle N is visible on pix_data in cycle N+1.
  - Simultaneous push and pop leaves the count unchanged.
  - Pushes never overflow, guaranteed by the issue condition.
  - Pointers wrap modulo FIFO_DEPTH.
- Start latency: start accepted in cycle 0 gives m_read=1 in cycle 1.
- start while busy is ignored. num_words is not re-sampled mid-transfer.
- addr wraps modulo 2^ADDR_W with no error.

Test Plan:
- Reset mid-read: assert reset_n=0 while m_read=1 -> m_read=0 immediately; busy, done and pix_valid are 0; the next start operates normally.
- Single-word transfer: base=0x100, num=1; slave returns 0xBBBBAAAA with valid in the acceptance cycle; pix_ready=1 -> m_address=0x100, pixels 0xAAAA (pix_sof=1) then 0xBBBB (pix_last=1); done pulses once.
- Back-pressure: num=16, FIFO_DEPTH=8, pix_ready=0 -> exactly 8 reads at 0x0,0x4,...,0x1C, then m_read stays 0. Releasing pix_ready -> the remaining 8 reads complete and 32 pixels emerge in address order.
- Delayed data: m_waitrequest held 3 cycles, then readdatavalid 2 cycles after acceptance -> m_address stable during the stall, no second read issued before data arrives, FSM passes through WAIT_DATA.
- Zero length and unaligned base: num=0 -> done one cycle after start with no m_read; base=0x103 -> first m_address=0x100.
- start while busy: extra start pulses and changed num_words mid-transfer -> ignored; the original count completes with one done pulse.
